// File: rtl/flash_op_sched_pkg.sv
// Shared definitions for the flash operation scheduler.
// Contents: opcode encodings, scheduler FSM state encoding, engine idle-bit
// index, page size limit, and a helper that flags unserviceable sizes.
package flash_op_sched_pkg;

   typedef enum logic [1:0] {
      OpRead      = 2'b00,
      OpProg      = 2'b01,
      OpSectErase = 2'b10,
      OpBulkErase = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWren     = 3'd1,
      StWrenWait = 3'd2,
      StOp       = 3'd3,
      StOpWait   = 3'd4,
      StDone     = 3'd5
   } state_e;

   localparam int unsigned EngIdleBit = 0;
   localparam int unsigned PageBytes  = 256;

   // A read needs at least one byte; a program must fit in a single page.
   function automatic logic size_bad(input op_e op, input logic [9:0] size);
      logic bad;
      bad = 1'b0;
      unique case (op)
         OpRead:      bad = (size == 10'd0);
         OpProg:      bad = (size == 10'd0) || (size > 10'(PageBytes));
         OpSectErase: bad = 1'b0;
         OpBulkErase: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/flash_op_sched_rr_arb.sv
// flash_rr_arb: two-way arbiter with a last-served pointer.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   req_a_i, req_b_i   pending requests
//   take_i             the current grant is consumed this cycle
//   gnt_a_o, gnt_b_o   combinational one-hot (or zero) grant
// With RrEn=0 requester A always wins a tie.
module flash_rr_arb #(
   parameter bit RrEn = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_a_i,
   input  logic req_b_i,
   input  logic take_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);

   // Set when A was served last, giving B the next tie.
   logic prio_b_q, prio_b_d;

   always_comb begin
      gnt_a_o = 1'b0;
      gnt_b_o = 1'b0;
      if (RrEn && prio_b_q) begin
         gnt_b_o = req_b_i;
         gnt_a_o = req_a_i & ~req_b_i;
      end else begin
         gnt_a_o = req_a_i;
         gnt_b_o = req_b_i & ~req_a_i;
      end
   end

   always_comb begin
      prio_b_d = prio_b_q;
      if (take_i) begin
         prio_b_d = gnt_a_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prio_b_q <= 1'b0;
      end else begin
         prio_b_q <= prio_b_d;
      end
   end

endmodule

// File: rtl/flash_op_sched.sv
// flash_op_sched: arbitrates two requesters (A, B) onto a single flash engine
// and sequences write-enable + operation pulses against the engine's state.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   {a,b}_req/op/addr/size        requester command, held until grant
//   {a,b}_grant/done/err          one-cycle handshake pulses per requester
//   eng_*_req / eng_read_rq       one-cycle engine request pulses
//   eng_addr, eng_size            captured command, stable until done
//   eng_state                     engine one-hot state, bit 0 = idle
//   busy                          scheduler not in IDLE
module flash_op_sched
   import flash_op_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 32'd70_000_000,
   parameter bit          RR_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic [1:0]  a_op,
   input  logic [23:0] a_addr,
   input  logic [9:0]  a_size,
   output logic        a_grant,
   output logic        a_done,
   output logic        a_err,
   input  logic        b_req,
   input  logic [1:0]  b_op,
   input  logic [23:0] b_addr,
   input  logic [9:0]  b_size,
   output logic        b_grant,
   output logic        b_done,
   output logic        b_err,
   output logic        eng_read_rq,
   output logic        eng_write_en_req,
   output logic        eng_write_req,
   output logic        eng_sector_erase_req,
   output logic        eng_bulk_erase_req,
   output logic [23:0] eng_addr,
   output logic [9:0]  eng_size,
   input  logic [12:0] eng_state,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        started_q, started_d;
   logic        err_q, err_d;
   logic        owner_b_q, owner_b_d;
   op_e         op_q, op_d;
   logic [23:0] addr_q, addr_d;
   logic [9:0]  size_q, size_d;
   logic        a_grant_q, a_grant_d, b_grant_q, b_grant_d;
   logic        rd_q, rd_d, wen_q, wen_d, wr_q, wr_d, se_q, se_d, be_q, be_d;

   logic        arb_gnt_a, arb_gnt_b, arb_take;
   logic        eng_idle;
   op_e         sel_op;
   logic [23:0] sel_addr;
   logic [9:0]  sel_size;
   logic [11:0] unused_eng_state;

   assign eng_idle         = eng_state[EngIdleBit];
   assign unused_eng_state = eng_state[12:1];

   assign sel_op   = arb_gnt_b ? op_e'(b_op) : op_e'(a_op);
   assign sel_addr = arb_gnt_b ? b_addr : a_addr;
   assign sel_size = arb_gnt_b ? b_size : a_size;

   flash_rr_arb #(
      .RrEn (RR_EN)
   ) u_arb (
      .clk_i   (clk),
      .rst_ni  (rst),
      .req_a_i (a_req),
      .req_b_i (b_req),
      .take_i  (arb_take),
      .gnt_a_o (arb_gnt_a),
      .gnt_b_o (arb_gnt_b)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         started_q <= 1'b0;
         err_q     <= 1'b0;
         owner_b_q <= 1'b0;
         op_q      <= OpRead;
         addr_q    <= '0;
         size_q    <= '0;
         a_grant_q <= 1'b0;
         b_grant_q <= 1'b0;
         rd_q      <= 1'b0;
         wen_q     <= 1'b0;
         wr_q      <= 1'b0;
         se_q      <= 1'b0;
         be_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         started_q <= started_d;
         err_q     <= err_d;
         owner_b_q <= owner_b_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         a_grant_q <= a_grant_d;
         b_grant_q <= b_grant_d;
         rd_q      <= rd_d;
         wen_q     <= wen_d;
         wr_q      <= wr_d;
         se_q      <= se_d;
         be_q      <= be_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      started_d = started_q;
      err_d     = err_q;
      owner_b_d = owner_b_q;
      op_d      = op_q;
      addr_d    = addr_q;
      size_d    = size_q;
      a_grant_d = 1'b0;
      b_grant_d = 1'b0;
      rd_d      = 1'b0;
      wen_d     = 1'b0;
      wr_d      = 1'b0;
      se_d      = 1'b0;
      be_d      = 1'b0;
      arb_take  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (arb_gnt_a || arb_gnt_b) begin
               arb_take  = 1'b1;
               owner_b_d = arb_gnt_b;
               op_d      = sel_op;
               addr_d    = sel_addr;
               size_d    = sel_size;
               // A bad size still walks through WREN/OP so done lands a cycle after grant.
               err_d     = size_bad(sel_op, sel_size);
               a_grant_d = arb_gnt_a;
               b_grant_d = arb_gnt_b;
               state_d   = (sel_op == OpRead) ? StOp : StWren;
            end
         end

         StWren: begin
            if (err_q) begin
               state_d = StDone;
            end else if (eng_idle) begin
               wen_d     = 1'b1;
               cnt_d     = '0;
               started_d = 1'b0;
               state_d   = StWrenWait;
            end
         end

         StOp: begin
            if (err_q) begin
               state_d = StDone;
            end else if (eng_idle) begin
               unique case (op_q)
                  OpRead:      rd_d = 1'b1;
                  OpProg:      wr_d = 1'b1;
                  OpSectErase: se_d = 1'b1;
                  OpBulkErase: be_d = 1'b1;
               endcase
               cnt_d     = '0;
               started_d = 1'b0;
               state_d   = StOpWait;
            end
         end

         StWrenWait, StOpWait: begin
            if (!eng_idle) begin
               started_d = 1'b1;
            end
            // Completion needs the engine to have left idle first, so the
            // idle cycle right after our pulse is not mistaken for "done".
            if (started_q && eng_idle) begin
               state_d = (state_q == StWrenWait) ? StOp : StDone;
            end else if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs
   always_comb begin
      busy   = (state_q != StIdle);
      a_done = 1'b0;
      a_err  = 1'b0;
      b_done = 1'b0;
      b_err  = 1'b0;
      if (state_q == StDone) begin
         a_done = ~owner_b_q;
         a_err  = ~owner_b_q & err_q;
         b_done = owner_b_q;
         b_err  = owner_b_q & err_q;
      end
      a_grant              = a_grant_q;
      b_grant              = b_grant_q;
      eng_read_rq          = rd_q;
      eng_write_en_req     = wen_q;
      eng_write_req        = wr_q;
      eng_sector_erase_req = se_q;
      eng_bulk_erase_req   = be_q;
      eng_addr             = addr_q;
      eng_size             = size_q;
   end

endmodule

// File: tb/tb_flash_op_sched.sv
// Bench for flash_op_sched: a round-robin instance with a full scoreboard and
// a fixed-priority instance checked for grant order.
module tb_flash_op_sched;
   import flash_op_sched_pkg::*;

   localparam int unsigned To     = 100;
   localparam int          EngLat = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Round-robin instance
   logic        a_req, b_req;
   logic [1:0]  a_op, b_op;
   logic [23:0] a_addr, b_addr;
   logic [9:0]  a_size, b_size;
   logic        a_grant, a_done, a_err, b_grant, b_done, b_err;
   logic        rd, wen, wr, se, be, busy;
   logic [23:0] eng_addr;
   logic [9:0]  eng_size;
   logic [12:0] eng_state;
   logic [45:0] outs;

   assign outs = {a_grant, a_done, a_err, b_grant, b_done, b_err, rd, wen, wr, se, be,
                  eng_addr, eng_size, busy};

   flash_op_sched #(
      .TIMEOUT_CYC (To),
      .RR_EN       (1'b1)
   ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .a_req                (a_req),
      .a_op                 (a_op),
      .a_addr               (a_addr),
      .a_size               (a_size),
      .a_grant              (a_grant),
      .a_done               (a_done),
      .a_err                (a_err),
      .b_req                (b_req),
      .b_op                 (b_op),
      .b_addr               (b_addr),
      .b_size               (b_size),
      .b_grant              (b_grant),
      .b_done               (b_done),
      .b_err                (b_err),
      .eng_read_rq          (rd),
      .eng_write_en_req     (wen),
      .eng_write_req        (wr),
      .eng_sector_erase_req (se),
      .eng_bulk_erase_req   (be),
      .eng_addr             (eng_addr),
      .eng_size             (eng_size),
      .eng_state            (eng_state),
      .busy                 (busy)
   );

   // Fixed-priority instance
   logic        f_a_req, f_b_req;
   logic        f_a_grant, f_a_done, f_a_err, f_b_grant, f_b_done, f_b_err;
   logic        f_rd, f_wen, f_wr, f_se, f_be, f_busy;
   logic [23:0] f_eng_addr;
   logic [9:0]  f_eng_size;
   logic [12:0] f_eng_state;

   flash_op_sched #(
      .TIMEOUT_CYC (To),
      .RR_EN       (1'b0)
   ) u_dut_fp (
      .clk                  (clk),
      .rst                  (rst),
      .a_req                (f_a_req),
      .a_op                 (2'b00),
      .a_addr               (24'h000010),
      .a_size               (10'd1),
      .a_grant              (f_a_grant),
      .a_done               (f_a_done),
      .a_err                (f_a_err),
      .b_req                (f_b_req),
      .b_op                 (2'b00),
      .b_addr               (24'h000020),
      .b_size               (10'd1),
      .b_grant              (f_b_grant),
      .b_done               (f_b_done),
      .b_err                (f_b_err),
      .eng_read_rq          (f_rd),
      .eng_write_en_req     (f_wen),
      .eng_write_req        (f_wr),
      .eng_sector_erase_req (f_se),
      .eng_bulk_erase_req   (f_be),
      .eng_addr             (f_eng_addr),
      .eng_size             (f_eng_size),
      .eng_state            (f_eng_state),
      .busy                 (f_busy)
   );

   // Engine models: busy for a fixed time after any request; "hang" keeps the
   // main engine busy after a pulse until hang is released.
   logic hang;
   int   eng_busy, f_eng_busy;
   logic eng_stuck;

   always @(posedge clk) begin
      if (!rst) begin
         eng_busy  <= 0;
         eng_stuck <= 1'b0;
      end else begin
         eng_stuck <= hang && (eng_stuck || (rd | wen | wr | se | be));
         if ((rd | wen | wr | se | be) && !hang) eng_busy <= EngLat;
         else if (eng_busy != 0) eng_busy <= eng_busy - 1;
      end
   end
   assign eng_state = (eng_busy != 0 || eng_stuck) ? 13'h002 : 13'h001;

   always @(posedge clk) begin
      if (!rst) f_eng_busy <= 0;
      else if (f_rd | f_wen | f_wr | f_se | f_be) f_eng_busy <= 5;
      else if (f_eng_busy != 0) f_eng_busy <= f_eng_busy - 1;
   end
   assign f_eng_state = (f_eng_busy != 0) ? 13'h002 : 13'h001;

   // Scoreboard
   typedef struct packed {
      logic        own_b;
      logic [1:0]  op;
      logic        err;
      logic [23:0] addr;
      logic [9:0]  size;
      logic [1:0]  npulse;
      logic        tmo;
      logic        fast;
   } exp_t;

   exp_t exp_q[$];
   logic gnt_q[$];
   logic f_gnt_q[$];
   int   total = 0;
   int   bad = 0;
   int   pulse_cnt = 0;
   int   wait_entry = 0;
   int   gnt_cyc = 0;
   logic prev_pulse = 1'b0;
   exp_t e;
   logic [4:0] p;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Expected pulse vector {rd,wen,wr,se,be} for the idx-th pulse of an op.
   function automatic logic [4:0] exp_pulse(input logic [1:0] op, input int idx);
      if (op == 2'b00) return 5'b10000;
      if (idx == 0) return 5'b01000;
      case (op)
         2'b01:   return 5'b00100;
         2'b10:   return 5'b00010;
         default: return 5'b00001;
      endcase
   endfunction

   task automatic push_exp(input logic own_b, input logic [1:0] op, input logic [23:0] addr,
                           input logic [9:0] size, input logic tmo);
      exp_t x;
      logic inval;
      inval    = (op == 2'b00 && size == 0) || (op == 2'b01 && (size == 0 || size > 256));
      x.own_b  = own_b;
      x.op     = op;
      x.err    = inval || tmo;
      x.addr   = addr;
      x.size   = size;
      x.npulse = inval ? 2'd0 : ((op == 2'b00) ? 2'd1 : 2'd2);
      x.tmo    = tmo;
      x.fast   = inval;
      exp_q.push_back(x);
      gnt_q.push_back(own_b);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         p = {rd, wen, wr, se, be};
         if (p != 5'b0) begin
            check("pulse_back_to_back", 64'(prev_pulse), 64'd0);
            if (exp_q.size() > 0) begin
               check("pulse_kind", 64'(p), 64'(exp_pulse(exp_q[0].op, pulse_cnt)));
               check("eng_addr_at_pulse", 64'(eng_addr), 64'(exp_q[0].addr));
               if (wr) check("eng_size_at_write", 64'(eng_size), 64'(exp_q[0].size));
            end
            pulse_cnt++;
            wait_entry = cyc;
         end
         prev_pulse = (p != 5'b0);
         if (a_grant || b_grant) begin
            check("grant_both", 64'(a_grant && b_grant), 64'd0);
            if (gnt_q.size() == 0) check("grant_unexpected", 64'd1, 64'd0);
            else check("grant_owner", 64'(b_grant), 64'(gnt_q.pop_front()));
            pulse_cnt = 0;
            gnt_cyc   = cyc;
         end
         if (a_done || b_done) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", 64'({a_done, b_done}), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("done_owner", 64'({a_done, b_done}), e.own_b ? 64'd1 : 64'd2);
               check("done_err", 64'({a_err, b_err}), e.err ? (e.own_b ? 64'd1 : 64'd2) : 64'd0);
               check("done_npulse", 64'(pulse_cnt), 64'(e.npulse));
               check("done_eng_addr", 64'(eng_addr), 64'(e.addr));
               check("done_eng_size", 64'(eng_size), 64'(e.size));
               if (e.tmo) check("timeout_latency", 64'(cyc - wait_entry), 64'(To));
               if (e.fast) check("bad_size_latency", 64'(cyc - gnt_cyc), 64'd1);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst && (f_a_grant || f_b_grant)) begin
         if (f_gnt_q.size() == 0) check("fp_grant_unexpected", 64'd1, 64'd0);
         else check("fp_grant_owner", 64'(f_b_grant), 64'(f_gnt_q.pop_front()));
      end
   end

   task automatic drive(input logic is_b, input logic [1:0] op, input logic [23:0] addr,
                        input logic [9:0] size, input logic wait_done);
      logic got;
      got = 1'b0;
      if (is_b) begin
         b_req = 1'b1; b_op = op; b_addr = addr; b_size = size;
      end else begin
         a_req = 1'b1; a_op = op; a_addr = addr; a_size = size;
      end
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (is_b ? b_grant : a_grant) begin
            got = 1'b1;
            break;
         end
      end
      check("grant_wait", 64'(got), 64'd1);
      if (is_b) b_req = 1'b0;
      else a_req = 1'b0;
      if (wait_done) begin
         got = 1'b0;
         for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (is_b ? b_done : a_done) begin
               got = 1'b1;
               break;
            end
         end
         check("done_wait", 64'(got), 64'd1);
      end
   endtask

   task automatic drive_f(input logic is_b);
      logic got;
      got = 1'b0;
      if (is_b) f_b_req = 1'b1;
      else f_a_req = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (is_b ? f_b_grant : f_a_grant) begin
            got = 1'b1;
            break;
         end
      end
      check("fp_grant_wait", 64'(got), 64'd1);
      if (is_b) f_b_req = 1'b0;
      else f_a_req = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (is_b ? f_b_done : f_a_done) begin
            got = 1'b1;
            break;
         end
      end
      check("fp_done_wait", 64'(got), 64'd1);
   endtask

   task automatic wait_pulse(input int which, input string tag);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if ((which == 0) ? wen : se) begin
            got = 1'b1;
            break;
         end
      end
      check(tag, 64'(got), 64'd1);
   endtask

   initial begin
      rst = 1'b0;
      hang = 1'b0;
      a_req = 1'b0; a_op = 2'b00; a_addr = '0; a_size = '0;
      b_req = 1'b0; b_op = 2'b00; b_addr = '0; b_size = '0;
      f_a_req = 1'b0; f_b_req = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(outs), 64'd0);
      check("reset_fp_busy", 64'({f_a_grant, f_b_grant, f_a_done, f_b_done, f_busy}), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Plain read from A
      push_exp(1'b0, OpRead, 24'h001000, 10'd4, 1'b0);
      drive(1'b0, OpRead, 24'h001000, 10'd4, 1'b1);
      // Page program from B
      push_exp(1'b1, OpProg, 24'h002000, 10'd16, 1'b0);
      drive(1'b1, OpProg, 24'h002000, 10'd16, 1'b1);
      // Size boundaries
      push_exp(1'b1, OpProg, 24'h003000, 10'd0, 1'b0);
      drive(1'b1, OpProg, 24'h003000, 10'd0, 1'b1);
      push_exp(1'b0, OpRead, 24'h004000, 10'd0, 1'b0);
      drive(1'b0, OpRead, 24'h004000, 10'd0, 1'b1);
      push_exp(1'b0, OpProg, 24'h005000, 10'd257, 1'b0);
      drive(1'b0, OpProg, 24'h005000, 10'd257, 1'b1);
      push_exp(1'b1, OpProg, 24'h006000, 10'd256, 1'b0);
      drive(1'b1, OpProg, 24'h006000, 10'd256, 1'b1);
      push_exp(1'b0, OpRead, 24'h007000, 10'd1023, 1'b0);
      drive(1'b0, OpRead, 24'h007000, 10'd1023, 1'b1);
      // Erases
      push_exp(1'b0, OpSectErase, 24'h010000, 10'd1, 1'b0);
      drive(1'b0, OpSectErase, 24'h010000, 10'd1, 1'b1);
      push_exp(1'b1, OpBulkErase, 24'h000000, 10'd1, 1'b0);
      drive(1'b1, OpBulkErase, 24'h000000, 10'd1, 1'b1);

      // Contention: round-robin alternates, fixed priority favours A
      push_exp(1'b0, OpRead, 24'h000100, 10'd8, 1'b0);
      push_exp(1'b1, OpRead, 24'h000200, 10'd8, 1'b0);
      push_exp(1'b0, OpRead, 24'h000300, 10'd8, 1'b0);
      push_exp(1'b1, OpRead, 24'h000400, 10'd8, 1'b0);
      f_gnt_q.push_back(1'b0);
      f_gnt_q.push_back(1'b0);
      f_gnt_q.push_back(1'b1);
      f_gnt_q.push_back(1'b1);
      fork
         begin
            drive(1'b0, OpRead, 24'h000100, 10'd8, 1'b1);
            drive(1'b0, OpRead, 24'h000300, 10'd8, 1'b1);
         end
         begin
            drive(1'b1, OpRead, 24'h000200, 10'd8, 1'b1);
            drive(1'b1, OpRead, 24'h000400, 10'd8, 1'b1);
         end
         begin
            drive_f(1'b0);
            drive_f(1'b0);
         end
         begin
            drive_f(1'b1);
            drive_f(1'b1);
         end
      join
      check("fp_grants_left", 64'(f_gnt_q.size()), 64'd0);

      // Engine never returns idle: timeout
      hang = 1'b1;
      push_exp(1'b0, OpRead, 24'h00a000, 10'd2, 1'b1);
      drive(1'b0, OpRead, 24'h00a000, 10'd2, 1'b1);
      @(negedge clk);
      check("idle_after_timeout", 64'(busy), 64'd0);
      hang = 1'b0;
      repeat (3) @(negedge clk);

      // Reset during OP_WAIT of a sector erase
      gnt_q.push_back(1'b1);
      drive(1'b1, OpSectErase, 24'h030000, 10'd1, 1'b0);
      wait_pulse(0, "wren_before_reset");
      @(negedge clk);
      hang = 1'b1;
      wait_pulse(1, "erase_before_reset");
      repeat (3) @(negedge clk);
      check("busy_in_op_wait", 64'(busy), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      check("outputs_after_reset", 64'(outs), 64'd0);
      rst = 1'b1;
      hang = 1'b0;
      repeat (30) @(negedge clk);
      check("idle_after_reset", 64'(busy), 64'd0);

      // Normal service after reset
      push_exp(1'b0, OpRead, 24'h040000, 10'd4, 1'b0);
      drive(1'b0, OpRead, 24'h040000, 10'd4, 1'b1);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("grants_left", 64'(gnt_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
